mips_div_seq: RTL and testbench
===============================

// Module: mips_div_seq
// PURPOSE
//  Sequential restoring divider for the MIPS ALU: the inverse of the multiply/add datapath.
//  Produces quotient (LO) and remainder (HI) for DIV/DIVU, one quotient bit per cycle.
//  Partial-remainder subtraction reuses the team's 4-bit carry-lookahead adder slices.
//  Sits beside the combinational ALU and is controlled by a start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand and result width; must be a multiple of 4 and at least 8
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only when the block is idle or in DONE
//  is_signed    in   1      1 = DIV (two's complement), 0 = DIVU
//  dividend     in   WIDTH  captured on the accepted start
//  divisor      in   WIDTH  captured on the accepted start
//  busy         out  1      operation in progress
//  done         out  1      one-cycle pulse; results are valid from this cycle on
//  quotient     out  WIDTH  LO result, held until the next accepted start
//  remainder    out  WIDTH  HI result, held until the next accepted start
//  div_by_zero  out  1      divisor was 0; valid with done, held like the results
// BEHAVIOUR
//  Reset: state IDLE. busy, done, quotient, remainder and div_by_zero are all 0.
//  States: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
//  - A start accepted in DONE goes straight to PREP.
//  Start at edge N:
//  - busy=1 from after edge N through edge N+WIDTH+1.
//  - At edge N+WIDTH+2: done=1 and busy=0 for exactly one cycle.
//  - Results update on that same edge.
//  start while busy=1 is ignored. Operands are not re-sampled and there is no error indication.
//  PREP: latch the operands and record the signs. In signed mode, take magnitudes.
//  - The magnitude of the most negative value is its own unsigned bit pattern.
//  CALC, each cycle:
//  - rem = {rem[W-2:0], q_msb}
//  - trial = rem - divisor via the add/sub unit (B inverted, Cin=1)
//  - No borrow: rem = trial and shift in a quotient bit of 1. Otherwise shift in 0.
//  - The cycle counter counts down from WIDTH-1. It is clog2(WIDTH) bits wide and does not wrap.
//  FIX, signed mode only:
//  - Negate the quotient if the operand signs differ.
//  - Negate the remainder if the dividend is negative.
//  Divide by zero: quotient = all ones, remainder = dividend (raw), div_by_zero=1, no sign fix.
//  - It still takes the full latency.
//  Overflow: signed 0x80000000 / -1 gives quotient 0x80000000 and remainder 0. No flag is raised.
//  rst mid-operation: the operation is abandoned and all outputs are zeroed on that edge.
//  - No done pulse is produced for the abandoned operation.
// CONFIGURATION
//  Macro MIPS_DIV_SIGNED_EN:
//  - Defined: is_signed is honoured as described above.
//  - Not defined: is_signed is ignored and every operation is DIVU.
//  - Not defined: the PREP magnitude logic and the FIX negation are not built.
//  - Not defined: FIX is a 1-cycle pass-through, so latency is unchanged.
// STRUCTURE
//  The shared package alu_pkg holds:
//  - the state encoding localparams: IDLE, PREP, CALC, FIX, DONE
//  - DIV_LATENCY = WIDTH+2
//  Sub-module: div_addsub, a WIDTH-bit add/subtract unit.
//  - Built as WIDTH/4 4-bit CLA slices.
//  - Ports: a, b, sub -> sum, cout. cout=1 means no borrow.
//  - It is also used for the FIX negation (0 - x).
// TESTING  (WIDTH=32)
//  - DIVU 100/7, start at edge N -> done at edge N+34. Expect q=14, r=2, div_by_zero=0.
//  - DIVU 0xFFFFFFFF/0 -> q=0xFFFFFFFF, r=0xFFFFFFFF, div_by_zero=1, with the same latency.
//  - DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//  - DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//  - Without the macro: the same DIV -7/2 (is_signed=1) is treated as DIVU.
//    Expect q=0x7FFFFFFC, r=1.
//  - Start at cycle 5 with operands 50/5. Pulse start again at cycle 10 with 9/3.
//    Expect a single done with q=10, r=0.
//  - Next, assert start in the done cycle -> busy the following cycle, with a second done 34 cycles later.
//  - Assert rst at cycle 15 of an operation -> all outputs 0 next cycle.
//    No done follows. A new start then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS ALU divider: state encoding, latency, 4-bit CLA slice.
package alu_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] CALC = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE = IDLE,
    S_PREP = PREP,
    S_CALC = CALC,
    S_FIX  = FIX,
    S_DONE = DONE
  } div_state_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
  } cla4_t;

  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    cla4_t      r;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
    r.sum  = p ^ c;
    return r;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// WIDTH-bit add/subtract built from 4-bit carry-lookahead slices; cout=1 on subtract means no borrow.
module div_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICES = WIDTH / 4;

  logic [SLICES:0] carry;

  // Subtraction is a + ~b + 1: the slice inputs are inverted and sub feeds the first carry-in.
  assign carry[0] = sub;

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    cla4_t r;
    assign r              = cla4(a[4*s +: 4], b[4*s +: 4] ^ {4{sub}}, carry[s]);
    assign sum[4*s +: 4]  = r.sum;
    assign carry[s+1]     = r.cout;
  end

  assign cout = carry[SLICES];

endmodule

// File: rtl/mips_div_seq.sv
// Sequential restoring divider (DIV/DIVU) for the MIPS ALU, one quotient bit per cycle.
// Signed support is built only when MIPS_DIV_SIGNED_EN is defined; otherwise every op is DIVU.
module mips_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;

  logic             accept;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             take;

  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign rem_shift = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
  // A bit shifted out of the partial remainder means it already exceeds any divisor.
  assign take      = as_cout | rem_q[WIDTH-1];

`ifdef MIPS_DIV_SIGNED_EN
  logic             sgn_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] rem_neg;
  logic             unused_rem_neg_cout;

  assign dvd_neg = sgn_q & dvd_q[WIDTH-1];
  assign dvs_neg = sgn_q & dvs_q[WIDTH-1];

  // In FIX the trial subtractor is idle, so it computes 0 - quotient instead.
  assign as_a = (state_q == S_FIX) ? '0  : rem_shift;
  assign as_b = (state_q == S_FIX) ? q_q : dvs_q;

  div_addsub #(.WIDTH(WIDTH)) u_rem_neg (
    .a    ('0),
    .b    (rem_q),
    .sub  (1'b1),
    .sum  (rem_neg),
    .cout (unused_rem_neg_cout)
  );
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign as_a             = rem_shift;
  assign as_b             = dvs_q;
`endif

  div_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (1'b1),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: begin
        busy    = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_PREP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef MIPS_DIV_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
`ifdef MIPS_DIV_SIGNED_EN
        sgn_q <= is_signed;
`endif
      end
      unique case (state_q)
        S_PREP: begin
          rem_q  <= '0;
          cnt_q  <= CW'(WIDTH - 1);
          zero_q <= (dvs_q == '0);
`ifdef MIPS_DIV_SIGNED_EN
          // Negating the most negative value yields its own pattern, which is the correct magnitude.
          q_q       <= dvd_neg ? -dvd_q : dvd_q;
          dvs_q     <= dvs_neg ? -dvs_q : dvs_q;
          neg_quo_q <= dvd_neg ^ dvs_neg;
          neg_rem_q <= dvd_neg;
`else
          q_q <= dvd_q;
`endif
        end
        S_CALC: begin
          rem_q <= take ? as_sum : rem_shift;
          q_q   <= {q_q[WIDTH-2:0], take};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          div_by_zero <= zero_q;
          if (zero_q) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else begin
`ifdef MIPS_DIV_SIGNED_EN
            quotient  <= neg_quo_q ? as_sum  : q_q;
            remainder <= neg_rem_q ? rem_neg : rem_q;
`else
            quotient  <= q_q;
            remainder <= rem_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_seq.sv
// Directed self-checking bench for mips_div_seq (WIDTH=32); expectations follow MIPS_DIV_SIGNED_EN.
module tb_mips_div_seq;

  localparam int LAT = 34;

`ifdef MIPS_DIV_SIGNED_EN
  localparam logic [31:0] NEG7_Q = 32'hFFFF_FFFD;
  localparam logic [31:0] NEG7_R = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;
  localparam logic [31:0] OVF_R  = 32'h0000_0000;
`else
  localparam logic [31:0] NEG7_Q = 32'h7FFF_FFFC;
  localparam logic [31:0] NEG7_R = 32'h0000_0001;
  localparam logic [31:0] OVF_Q  = 32'h0000_0000;
  localparam logic [31:0] OVF_R  = 32'h8000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents start for one edge; returns 1 time unit after that edge.
  task automatic issue(input logic sg, input logic [31:0] dd, input logic [31:0] ds);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sg;
    dividend  = dd;
    divisor   = ds;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the edge count from the accepting edge to the first done, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
  endtask

  task automatic run(input string tag, input logic sg, input logic [31:0] dd, input logic [31:0] ds,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int lat;
    issue(sg, dd, ds);
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " done_after_start"}, done, 0);
    wait_done(lat);
    check({tag, " latency"}, lat, LAT);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
  endtask

  initial begin
    int lat;
    int ndone;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run("divu_by_zero", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // The done pulse lasts one cycle and the block returns idle without a new start.
    @(posedge clk);
    #1;
    check("pulse done_cleared", done, 0);
    check("pulse busy_idle", busy, 0);
    check("pulse result_held", quotient, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);

    run("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, NEG7_Q, NEG7_R, 1'b0);
    run("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, OVF_Q, OVF_R, 1'b0);
    run("divu_big_divisor", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);
    run("div_signed_by_zero", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    repeat (3) @(posedge clk);

    // A second start five cycles into an operation is ignored.
    issue(1'b0, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    ndone = 0;
    for (int k = 6; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    check("ignored_start done_count", ndone, 1);
    check("ignored_start latency", lat, LAT);
    check("ignored_start quotient", quotient, 32'd10);
    check("ignored_start remainder", remainder, 32'd0);

    // Back-to-back: the second start lands in the done cycle of the first.
    run("chain_a", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    run("chain_b", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);

    // Reset fifteen cycles into an operation abandons it.
    repeat (3) @(posedge clk);
    issue(1'b0, 32'd12345, 32'd67);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst no_done", ndone, 0);
    run("after_rst", 1'b0, 32'd77, 32'd8, 32'd9, 32'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
